// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_req_arbiter
//  Purpose  : Round-robin arbiter sharing one SPI memory transaction engine
//             between NREQ requesters, with local address-range rejection
//             and a watchdog that aborts engine transactions that hang.
//  Revision : 1.0  initial release
// ============================================================================
module spi_req_arbiter #(
    parameter int NREQ      = 2,
    parameter int MEM_DEPTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rsp_dout,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              m_req,
    output logic              m_wr,
    output logic [7:0]        m_addr,
    output logic [7:0]        m_din,
    input  logic [7:0]        m_dout,
    input  logic              m_done,
    input  logic              m_err
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REJECT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             m_req_q, m_req_d;
    logic             m_wr_q, m_wr_d;
    logic [7:0]       m_addr_q, m_addr_d;
    logic [7:0]       m_din_q, m_din_d;
    logic [7:0]       rsp_dout_q, rsp_dout_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [RRW-1:0]   rr_q, rr_d;
    logic [RRW-1:0]   win_q, win_d;

    logic             found;
    logic [RRW-1:0]   pick;
    logic [7:0]       sel_addr;
    int               idx;

    // Round-robin search: first requesting index at or above rr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = RRW'(idx);
            end
        end
        sel_addr = req_addr[8*int'(pick) +: 8];
    end

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ack_d         = '0;
        m_req_d       = m_req_q;
        m_wr_d        = m_wr_q;
        m_addr_d      = m_addr_q;
        m_din_d       = m_din_q;
        rsp_dout_d    = rsp_dout_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wdog_d        = wdog_q;
        rr_d          = rr_q;
        win_d         = win_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d    = pick;
                    gnt_d    = NREQ'(1) << pick;
                    m_wr_d   = req_wr[pick];
                    m_addr_d = sel_addr;
                    m_din_d  = req_din[8*int'(pick) +: 8];
                    wdog_d   = '0;
                    if (int'(sel_addr) >= MEM_DEPTH) begin
                        state_d = S_REJECT;
                    end else begin
                        m_req_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Engine completion takes priority over a coincident timeout.
                if (m_done) begin
                    rsp_dout_d    = m_dout;
                    rsp_err_d     = m_err;
                    rsp_timeout_d = 1'b0;
                    m_req_d       = 1'b0;
                    ack_d         = NREQ'(1) << win_q;
                    state_d       = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    rsp_dout_d    = 8'h00;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    m_req_d       = 1'b0;
                    ack_d         = NREQ'(1) << win_q;
                    state_d       = S_RESP;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_REJECT: begin
                rsp_dout_d    = 8'h00;
                rsp_err_d     = 1'b1;
                rsp_timeout_d = 1'b0;
                ack_d         = NREQ'(1) << win_q;
                state_d       = S_RESP;
            end
            default: begin
                // S_RESP: ack is high this cycle; rotate priority past winner.
                gnt_d   = '0;
                wdog_d  = '0;
                rr_d    = (win_q == RRW'(NREQ - 1)) ? '0 : win_q + RRW'(1);
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops m_req/gnt immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            ack_q         <= '0;
            m_req_q       <= 1'b0;
            m_wr_q        <= 1'b0;
            m_addr_q      <= 8'h00;
            m_din_q       <= 8'h00;
            rsp_dout_q    <= 8'h00;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wdog_q        <= '0;
            rr_q          <= '0;
            win_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            m_req_q       <= m_req_d;
            m_wr_q        <= m_wr_d;
            m_addr_q      <= m_addr_d;
            m_din_q       <= m_din_d;
            rsp_dout_q    <= rsp_dout_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wdog_q        <= wdog_d;
            rr_q          <= rr_d;
            win_q         <= win_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign m_req       = m_req_q;
    assign m_wr        = m_wr_q;
    assign m_addr      = m_addr_q;
    assign m_din       = m_din_q;
    assign rsp_dout    = rsp_dout_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one SPI memory transaction engine (wr/addr/din in, dout/done/err out) between NREQ independent requesters.
- Round-robin arbitration; the granted command is latched and held stable for the engine until completion.
- Responses are routed back to the winning requester; addresses out of range are rejected locally.
- A watchdog aborts engine transactions that never complete.

Parameters:
- NREQ, 2: number of requesters (2..8).
- MEM_DEPTH, 32: valid addresses are 0..MEM_DEPTH-1.
- TIMEOUT, 64: max cycles to wait for m_done after m_req rises (>=2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  per-requester request level; held high until matching ack.
- req_wr  in  NREQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  8*NREQ  requester i address in bits [8i+7:8i].
- req_din  in  8*NREQ  requester i write data in bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant, high for the whole transaction.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_dout  out  8  read data; valid while any ack bit is high.
- rsp_err  out  1  error flag; valid while any ack bit is high.
- rsp_timeout  out  1  high with ack when the error was a watchdog abort.
- m_req  out  1  command valid to the engine; held until m_done or abort.
- m_wr  out  1  latched op.
- m_addr  out  8  latched address.
- m_din  out  8  latched data.
- m_dout  in  8  engine read data; valid with m_done.
- m_done  in  1  engine completion pulse.
- m_err  in  1  engine error; valid with m_done.

Behaviour:
- Reset (async assert; sync release on clk):
  - state = IDLE; gnt, ack, m_req, m_wr, m_addr, m_din, rsp_dout, rsp_err, rsp_timeout, wdog = 0.
  - Round-robin pointer rr = 0.
  - Reset mid-transaction drops m_req immediately. No ack is issued for the aborted op.
- IDLE:
  - If req != 0, select the first set bit searching from index rr upward with wrap-around.
  - Latch req_wr/req_addr/req_din of the winner into m_wr/m_addr/m_din. Set gnt one-hot.
  - If latched addr >= MEM_DEPTH, go REJECT. Otherwise go WAIT with m_req = 1.
  - Latency: req sampled high in IDLE -> m_req high on the next cycle.
- WAIT:
  - m_req stays high. wdog increments each cycle from 0.
  - m_done = 1: capture m_dout -> rsp_dout and m_err -> rsp_err; m_req = 0; go RESP.
  - Else if wdog == TIMEOUT-1: m_req = 0; rsp_err = 1; rsp_timeout = 1; go RESP.
  - m_done and the timeout in the same cycle: m_done wins, no timeout flag.
- REJECT: rsp_err = 1, rsp_dout = 0, m_req never asserted; go RESP.
- RESP:
  - ack[winner] = 1 for exactly one cycle; rsp_* held valid that cycle.
  - rr = (winner+1) mod NREQ. gnt cleared. wdog = 0. Go IDLE.
  - rsp_dout/rsp_err/rsp_timeout hold their values until the next RESP.
- Throughput: back-to-back requests incur IDLE + RESP overhead, so the minimum per-op cost is engine time + 2 cycles.
- Fairness: a requester holding req continuously is served at most once per NREQ grants while others are pending.
- Requester rules:
  - Inputs of the granted requester may change after the grant cycle; the latched copy is used.
  - req deasserted mid-transaction does not cancel: the op completes and ack still pulses.
  - A req asserted during WAIT or RESP is considered at the next IDLE.
- m_done arriving in IDLE, REJECT or RESP (stray or late after timeout) is ignored.
- Read ops: rsp_dout = m_dout. Write ops: rsp_dout = m_dout as returned by the engine; requesters ignore it.

Test Plan:
- Single write: req[0]=1, wr=1, addr=5, din=0xA5; engine returns m_done after 30 cycles -> m_req high the cycle after req, m_addr=5, m_din=0xA5, ack[0] pulses once, rsp_err=0.
- Single read: req[1]=1, wr=0, addr=5; engine m_dout=0xA5 with m_done -> ack[1] pulses with rsp_dout=0xA5, rsp_err=0.
- Contention: req=2'b11 held from reset -> grants in order 0,1,0,1; ack never fires on two bits at once.
- Out of range: req[0], addr=40 -> m_req stays 0; ack[0] pulses 2 cycles after req with rsp_err=1, rsp_timeout=0.
- Timeout: engine never drives m_done, TIMEOUT=64 -> m_req drops after 64 WAIT cycles; ack with rsp_err=1, rsp_timeout=1; a late m_done is ignored.
- Reset in WAIT: assert rst while m_req=1 -> m_req and gnt go 0 without a clock edge; no ack; after release, rr=0 and the next request is serviced normally.
